// File: rtl/mem_bus_bridge.sv
// MEM-stage load/store bridge: turns pipeline load/store requests into single
// bus transactions, stalls the pipeline meanwhile, and extends load data.
module mem_bus_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        access_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] read_data_q, read_data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic        access_err_q, access_err_d;

    logic        req;
    logic        size_ok;
    logic        aligned;
    logic        legal;
    logic [31:0] byte_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    // Write wins when both request strobes are high.
    always_comb begin
        req     = mem_read | mem_write;
        size_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = ~mem_write;
            default:                size_ok = 1'b0;
        endcase
        aligned = ~((funct3[1:0] == 2'b01 && address[0]) ||
                    (funct3[1:0] == 2'b10 && address[1:0] != 2'b00));
        legal   = size_ok & aligned;
    end

    always_comb begin
        byte_shift = bus_rdata >> {addr_q[1:0], 3'b000};
        ld_byte    = byte_shift[7:0];
        ld_half    = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        we_d         = we_q;
        read_data_d  = read_data_q;
        access_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && legal) begin
                    addr_d   = address;
                    wdata_d  = write_data;
                    funct3_d = funct3;
                    we_d     = mem_write;
                    state_d  = REQ;
                end else if (req) begin
                    access_err_d = 1'b1;
                end
            end
            REQ: begin
                // Stores are posted: no response phase.
                if (bus_req_ready) state_d = we_q ? DONE : RESP;
            end
            RESP: begin
                if (bus_resp_valid) begin
                    read_data_d = load_ext;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            read_data_q  <= '0;
            access_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            we_q         <= we_d;
            read_data_q  <= read_data_d;
            access_err_q <= access_err_d;
        end
    end

    always_comb begin
        bus_be    = 4'b1111;
        bus_wdata = wdata_q;
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    bus_be    = 4'b0001 << addr_q[1:0];
                    bus_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    bus_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    bus_be    = 4'b1111;
                    bus_wdata = wdata_q;
                end
            endcase
        end
    end

    // Stall is combinational so the pipeline freezes in the cycle the request appears.
    assign stall         = ~rst & ((state_q == IDLE && req && legal) ||
                                   state_q == REQ || state_q == RESP);
    assign bus_req_valid = (state_q == REQ);
    assign bus_we        = (state_q == REQ) & we_q;
    assign bus_addr      = {addr_q[31:2], 2'b00};
    assign read_data     = read_data_q;
    assign access_err    = access_err_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed self-checking bench for mem_bus_bridge: loads, stores, backpressure,
// illegal accesses and reset in the middle of a transaction.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] address, write_data;
    logic [2:0]  funct3;
    logic [31:0] read_data;
    logic        stall, access_err;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    int          stall_cyc;

    mem_bus_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .address        (address),
        .write_data     (write_data),
        .funct3         (funct3),
        .read_data      (read_data),
        .stall          (stall),
        .access_err     (access_err),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_be         (bus_be),
        .bus_resp_valid (bus_resp_valid),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One legal access; bus slave accepts after rdy_delay REQ cycles and
    // answers reads in the cycle after acceptance.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int rdy_delay);
        int req_seen = 0;
        bit accepted = 0;
        bit got_cap  = 0;
        bit done     = 0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; address = a; write_data = wd;
        bus_req_ready = (rdy_delay == 0); bus_resp_valid = 1'b0; bus_rdata = rdat;
        stall_cyc = 0;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            @(negedge clk);
            if (stall) stall_cyc++;
            else done = 1;
            if (bus_req_valid) begin
                req_seen++;
                if (!got_cap) begin
                    cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
                    got_cap = 1;
                end else begin
                    chk("hold_addr", bus_addr, cap_addr);
                    chk("hold_wdata", bus_wdata, cap_wdata);
                    chk("hold_be", {28'd0, bus_be}, {28'd0, cap_be});
                end
                if (bus_req_ready) accepted = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                bus_req_ready  = (req_seen >= rdy_delay);
                bus_resp_valid = accepted && rd && !wr;
            end
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        if (!got_cap) chk("no_bus_req", 32'd0, 32'd1);
        mem_read = 1'b0; mem_write = 1'b0; bus_resp_valid = 1'b0; bus_req_ready = 1'b0;
    endtask

    task automatic bad_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] exp_rd, input string tag);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; address = a; write_data = 32'h1234_5678;
        bus_req_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_valid0"}, {31'd0, bus_req_valid}, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk({tag, "_err"}, {31'd0, access_err}, 32'd1);
        chk({tag, "_valid1"}, {31'd0, bus_req_valid}, 32'd0);
        chk({tag, "_rdata"}, read_data, exp_rd);
        @(negedge clk);
        chk({tag, "_err_end"}, {31'd0, access_err}, 32'd0);
        bus_req_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
        funct3 = '0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_valid", {31'd0, bus_req_valid}, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_err", {31'd0, access_err}, 32'd0);
        rst = 1'b0;

        // LW 0x100
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_be", {28'd0, cap_be}, 32'hF);
        chk("lw_we", {31'd0, cap_we}, 32'd0);
        chk("lw_stall", stall_cyc, 3);
        chk("lw_rdata", read_data, 32'hDEAD_BEEF);

        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
        chk("lb_addr", cap_addr, 32'h100);
        chk("lb_rdata", read_data, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
        chk("lbu_rdata", read_data, 32'h0000_0080);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0);
        chk("lh_rdata", read_data, 32'hFFFF_8001);
        run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h8001_9234, 0);
        chk("lhu_rdata", read_data, 32'h0000_9234);
        run_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h1122_7F44, 0);
        chk("lb1_rdata", read_data, 32'h0000_007F);

        // SH with 3 cycles of backpressure
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 3);
        chk("sh_addr", cap_addr, 32'h200);
        chk("sh_be", {28'd0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, cap_we}, 32'd1);
        chk("sh_stall", stall_cyc, 5);
        chk("sh_rdata_kept", read_data, 32'h0000_007F);

        run_access(1'b0, 1'b1, 3'b000, 32'h011, 32'hFFFF_FF5A, 32'h0, 0);
        chk("sb_addr", cap_addr, 32'h10);
        chk("sb_be", {28'd0, cap_be}, 32'h2);
        chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
        chk("sb_stall", stall_cyc, 2);

        // read and write together behave as a store
        run_access(1'b1, 1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 32'h0BAD_0BAD, 0);
        chk("rw_we", {31'd0, cap_we}, 32'd1);
        chk("rw_be", {28'd0, cap_be}, 32'hF);
        chk("rw_wdata", cap_wdata, 32'hCAFE_F00D);
        chk("rw_stall", stall_cyc, 2);
        chk("rw_rdata_kept", read_data, 32'h0000_007F);

        bad_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0000_007F, "mis_lw");
        bad_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0000_007F, "ill_f3");
        bad_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0000_007F, "ill_st");
        bad_access(1'b0, 1'b1, 3'b001, 32'h201, 32'h0000_007F, "mis_sh");

        // reset while waiting for a read response
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; address = 32'h300; bus_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_req", {31'd0, bus_req_valid}, 32'd1);
        @(negedge clk);
        chk("mid_resp_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_valid", {31'd0, bus_req_valid}, 32'd0);
        chk("mid_stall", {31'd0, stall}, 32'd0);
        chk("mid_rdata", read_data, 32'd0);
        mem_read = 1'b0; bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rdata", read_data, 32'd0);
        chk("post_stall", {31'd0, stall}, 32'd0);
        chk("post_valid", {31'd0, bus_req_valid}, 32'd0);
        bus_resp_valid = 1'b0;

        run_access(1'b1, 1'b0, 3'b010, 32'h044, 32'h0, 32'h0102_0304, 0);
        chk("rec_rdata", read_data, 32'h0102_0304);
        chk("rec_stall", stall_cyc, 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
